// File: rtl/plic_lite.sv
// Platform-level interrupt arbiter: per-source gateways, priority/enable/threshold
// registers and claim/complete handshake, driving meip. Define PLIC_SYNC_EN to add a
// two-flop synchronizer on every src bit ahead of the gateways.
module plic_lite #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            mem_valid,
  input  logic            mem_wren,
  input  logic [15:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  output logic [31:0]     mem_rdata,
  output logic            mem_ready,
  output logic            meip
);

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_INFL = 2'd2
  } gw_state_e;

  gw_state_e         gw_q   [1:NSRC];
  gw_state_e         gw_d   [1:NSRC];
  logic [PRIO_W-1:0] prio_q [1:NSRC];
  logic [PRIO_W-1:0] prio_d [1:NSRC];
  logic [NSRC:1]     en_q, en_d;
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, meip_q;

  logic [NSRC-1:0]   src_s;
  logic [NSRC:1]     pend;
  logic [4:0]        best_id;
  logic [PRIO_W-1:0] best_prio;
  logic [9:0]        word;
  logic              sel_prio, sel_pend, sel_en, sel_thr, sel_claim;
  logic              rd, wr, claim, complete;
  logic              unused_bits;

`ifdef PLIC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  // Address decode; the low two address bits are don't-care for aligned accesses.
  assign word      = mem_addr[11:2];
  assign sel_prio  = (mem_addr[15:12] == 4'h0) && (word != 10'd0) && (word <= 10'(NSRC));
  assign sel_pend  = (mem_addr[15:2] == 14'h0400);
  assign sel_en    = (mem_addr[15:2] == 14'h0800);
  assign sel_thr   = (mem_addr[15:2] == 14'h0C00);
  assign sel_claim = (mem_addr[15:2] == 14'h0C01);

  assign rd       = mem_valid && !mem_wren;
  assign wr       = mem_valid && mem_wren;
  assign claim    = rd && sel_claim;
  assign complete = wr && sel_claim;

  assign unused_bits = ^{mem_wdata, mem_addr[1:0]};

  always_comb begin
    for (int i = 1; i <= NSRC; i++) begin
      pend[i] = (gw_q[i] == GW_PEND);
    end
  end

  // Strictly-greater scan from ID 1 upward keeps the lowest ID on priority ties.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (pend[i] && en_q[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        best_id   = 5'(i);
      end
    end
  end

  always_comb begin
    for (int i = 1; i <= NSRC; i++) begin
      gw_d[i] = gw_q[i];
      unique case (gw_q[i])
        GW_IDLE: if (src_s[i-1]) gw_d[i] = GW_PEND;
        GW_PEND: if (claim && (best_id == 5'(i))) gw_d[i] = GW_INFL;
        GW_INFL: if (complete && (mem_wdata[4:0] == 5'(i))) gw_d[i] = GW_IDLE;
        default: gw_d[i] = GW_IDLE;
      endcase
    end
  end

  always_comb begin
    en_d  = en_q;
    thr_d = thr_q;
    for (int i = 1; i <= NSRC; i++) begin
      prio_d[i] = prio_q[i];
      if (wr && sel_prio && (word == 10'(i))) prio_d[i] = mem_wdata[PRIO_W-1:0];
    end
    if (wr && sel_en)  en_d  = mem_wdata[NSRC:1];
    if (wr && sel_thr) thr_d = mem_wdata[PRIO_W-1:0];
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (sel_prio) begin
        for (int i = 1; i <= NSRC; i++) begin
          if (word == 10'(i)) rdata_d = 32'(prio_q[i]);
        end
      end
      if (sel_pend)  rdata_d = 32'({pend, 1'b0});
      if (sel_en)    rdata_d = 32'({en_q, 1'b0});
      if (sel_thr)   rdata_d = 32'(thr_q);
      if (sel_claim) rdata_d = 32'(best_id);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 1; i <= NSRC; i++) begin
        gw_q[i]   <= GW_IDLE;
        prio_q[i] <= '0;
      end
      en_q    <= '0;
      thr_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      meip_q  <= 1'b0;
    end else begin
      gw_q    <= gw_d;
      prio_q  <= prio_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      rdata_q <= rdata_d;
      ready_q <= mem_valid;
      meip_q  <= (best_prio > thr_q);
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign meip      = meip_q;

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: register access, gateway handshake, arbitration,
// threshold, level re-trigger, reset and disabled-source scenarios.
module tb_plic_lite;

  localparam int NSRC   = 8;
  localparam int PRIO_W = 3;
`ifdef PLIC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic            clock;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            mem_valid;
  logic            mem_wren;
  logic [15:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic            mem_ready;
  logic            meip;

  int n_chk;
  int n_fail;

  plic_lite #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .src       (src),
    .mem_valid (mem_valid),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .meip      (meip)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic src_settle();
    for (int k = 0; k < SYNC_LAT; k++) tick();
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    mem_valid = 1'b1;
    mem_wren  = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    tick();
    mem_valid = 1'b0;
    mem_wren  = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d, output logic rdy);
    mem_valid = 1'b1;
    mem_wren  = 1'b0;
    mem_addr  = a;
    tick();
    mem_valid = 1'b0;
    d   = mem_rdata;
    rdy = mem_ready;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    src       = '0;
    mem_valid = 1'b0;
    mem_wren  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    do_reset();
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL reset_meip: got %b want 0", meip); end
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
    n_chk++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
    bus_rd(16'h2000, d, r);
    n_chk++; if (r !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ready: got %b want 1", r); end
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_enable: got %h want 0", d); end
    bus_wr(16'h0008, 32'hFFFF_FFFF);
    bus_rd(16'h0008, d, r);
    n_chk++; if (d !== 32'h7) begin n_fail++; $display("FAIL prio_width: got %h want 7", d); end
    bus_wr(16'h0000, 32'h5);
    bus_rd(16'h0000, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL prio0_read: got %h want 0", d); end
    bus_rd(16'h4000, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        r;
    do_reset();
    bus_wr(16'h000C, 32'd2);
    bus_wr(16'h2000, 32'h08);
    bus_wr(16'h3000, 32'd0);
    src = 8'h04;
    src_settle();
    tick();
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL basic_meip_e1: got %b want 0", meip); end
    tick();
    n_chk++; if (meip !== 1'b1) begin n_fail++; $display("FAIL basic_meip_e2: got %b want 1", meip); end
    bus_rd(16'h3004, d, r);
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL basic_claim: got %0d want 3", d); end
    tick();
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL basic_meip_after_claim: got %b want 0", meip); end
    src = 8'h00;
    src_settle();
    bus_wr(16'h3004, 32'd3);
    tick();
    tick();
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL basic_meip_after_complete: got %b want 0", meip); end
    bus_rd(16'h1000, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL basic_pending: got %h want 0", d); end
  endtask

  task automatic test_arbitration();
    logic [31:0] d;
    logic        r;
    logic [31:0] exp_id [3];
    logic [7:0]  drop   [3];
    exp_id[0] = 32'd7; drop[0] = 8'h40;
    exp_id[1] = 32'd2; drop[1] = 8'h02;
    exp_id[2] = 32'd5; drop[2] = 8'h10;
    do_reset();
    bus_wr(16'h0008, 32'd4);
    bus_wr(16'h0014, 32'd4);
    bus_wr(16'h001C, 32'd6);
    bus_wr(16'h2000, 32'hA4);
    src = 8'h52;
    src_settle();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      bus_rd(16'h3004, d, r);
      n_chk++; if (d !== exp_id[k]) begin n_fail++; $display("FAIL arb_claim%0d: got %0d want %0d", k, d, exp_id[k]); end
      src = src & ~drop[k];
      src_settle();
      bus_wr(16'h3004, exp_id[k]);
    end
    bus_rd(16'h3004, d, r);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL arb_claim_empty: got %0d want 0", d); end
  endtask

  task automatic test_threshold();
    logic [31:0] d;
    logic        r;
    do_reset();
    bus_wr(16'h0004, 32'd3);
    bus_wr(16'h2000, 32'h02);
    bus_wr(16'h3000, 32'd3);
    src = 8'h01;
    src_settle();
    tick();
    tick();
    tick();
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL thr_equal_meip: got %b want 0", meip); end
    bus_rd(16'h1000, d, r);
    n_chk++; if (d !== 32'h02) begin n_fail++; $display("FAIL thr_pending: got %h want 02", d); end
    bus_wr(16'h3000, 32'd2);
    tick();
    n_chk++; if (meip !== 1'b1) begin n_fail++; $display("FAIL thr_lowered_meip: got %b want 1", meip); end
  endtask

  task automatic test_retrigger();
    logic [31:0] d;
    logic        r;
    do_reset();
    bus_wr(16'h0010, 32'd5);
    bus_wr(16'h2000, 32'h10);
    src = 8'h08;
    src_settle();
    tick();
    tick();
    bus_rd(16'h3004, d, r);
    n_chk++; if (d !== 32'd4) begin n_fail++; $display("FAIL retrig_claim: got %0d want 4", d); end
    bus_wr(16'h3004, 32'd6);
    bus_rd(16'h1000, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL retrig_bogus_pending: got %h want 0", d); end
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL retrig_bogus_meip: got %b want 0", meip); end
    bus_wr(16'h3004, 32'd4);
    tick();
    bus_rd(16'h1000, d, r);
    n_chk++; if (d !== 32'h10) begin n_fail++; $display("FAIL retrig_pending: got %h want 10", d); end
    n_chk++; if (meip !== 1'b1) begin n_fail++; $display("FAIL retrig_meip: got %b want 1", meip); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        r;
    do_reset();
    bus_wr(16'h0004, 32'd7);
    bus_wr(16'h2000, 32'h02);
    bus_wr(16'h3000, 32'd1);
    src = 8'h01;
    src_settle();
    tick();
    tick();
    n_chk++; if (meip !== 1'b1) begin n_fail++; $display("FAIL mid_meip_before: got %b want 1", meip); end
    mem_valid = 1'b1;
    mem_wren  = 1'b0;
    mem_addr  = 16'h3004;
    tick();
    mem_valid = 1'b0;
    reset     = 1'b0;
    src       = 8'h00;
    tick();
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", mem_ready); end
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL mid_meip: got %b want 0", meip); end
    reset = 1'b1;
    tick();
    bus_rd(16'h0004, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_prio1: got %h want 0", d); end
    bus_rd(16'h2000, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_enable: got %h want 0", d); end
    bus_rd(16'h3000, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_threshold: got %h want 0", d); end
    bus_rd(16'h1000, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_pending: got %h want 0", d); end
    bus_rd(16'h3004, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_claim: got %h want 0", d); end
  endtask

  task automatic test_disabled();
    logic [31:0] d;
    logic        r;
    do_reset();
    for (int i = 1; i <= NSRC; i++) bus_wr(16'(4 * i), 32'd7);
    bus_wr(16'h2000, 32'h0);
    src = 8'hFF;
    src_settle();
    tick();
    tick();
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL dis_meip: got %b want 0", meip); end
    bus_rd(16'h3004, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL dis_claim: got %0d want 0", d); end
    bus_rd(16'h1000, d, r);
    n_chk++; if (d !== 32'h1FE) begin n_fail++; $display("FAIL dis_pending: got %h want 1fe", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    bus_wr(16'h2000, 32'hFFFF_FFFF);
    bus_wr(16'h3000, 32'd5);
    mem_valid = 1'b1;
    mem_wren  = 1'b0;
    mem_addr  = 16'h2000;
    tick();
    d = mem_rdata;
    n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", mem_ready); end
    n_chk++; if (d !== 32'h1FE) begin n_fail++; $display("FAIL b2b_enable: got %h want 1fe", d); end
    mem_addr = 16'h3000;
    tick();
    mem_valid = 1'b0;
    d = mem_rdata;
    n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", mem_ready); end
    n_chk++; if (d !== 32'h5) begin n_fail++; $display("FAIL b2b_threshold: got %h want 5", d); end
    tick();
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_idle: got %b want 0", mem_ready); end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    src       = '0;
    mem_valid = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    test_reset();
    test_basic();
    test_arbitration();
    test_threshold();
    test_retrigger();
    test_reset_mid();
    test_disabled();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
- Platform-level interrupt arbiter that merges NSRC level-sensitive external interrupt sources onto the single `meip` input of the machine-mode CSR block.
- Per-source gateway, priority, enable, global threshold and claim/complete handshake.
- Accessed from the core's data bus as a memory-mapped peripheral.
- Sits between the SoC peripherals and the core's interrupt inputs, beside the timer/software-interrupt unit.

Parameters:
- NSRC, 8, number of interrupt sources, IDs 1..NSRC; ID 0 means "no interrupt"; legal range 1..31.
- PRIO_W, 3, priority field width in bits; priority 0 means "never interrupt".

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- src  input  NSRC  level interrupt requests; bit i-1 is source ID i.
- mem_valid  input  1  bus request strobe, single-cycle pulse.
- mem_wren  input  1  1 = write, 0 = read.
- mem_addr  input  16  byte offset within the block; must be word aligned.
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data, valid while mem_ready = 1.
- mem_ready  output  1  response pulse, one cycle after mem_valid.
- meip  output  1  machine external interrupt pending, to the CSR block.

Behaviour:
- Register map (word offsets):
  - 0x0000+4*i: priority[i], i = 1..NSRC, RW, low PRIO_W bits; offset 0x0000 reads 0.
  - 0x1000: pending bits [NSRC:1], RO.
  - 0x2000: enable bits [NSRC:1], RW.
  - 0x3000: threshold, RW, low PRIO_W bits.
  - 0x3004: claim (read) / complete (write).
- Unmapped reads return 0. Writes to unmapped or RO locations are ignored. Bits above field width read 0.
- Bus timing: every mem_valid gives mem_ready = 1 exactly one cycle later, with mem_rdata registered. No back-pressure. mem_valid while mem_ready = 1 is legal (back-to-back).
- Gateway per source, state IDLE/PEND/INFLIGHT:
  - IDLE -> PEND on a clock edge where src = 1.
  - PEND -> INFLIGHT on a claim returning this ID. The pending bit clears at that edge.
  - INFLIGHT -> IDLE on a complete write whose wdata[4:0] equals this ID.
  - src is ignored in PEND and INFLIGHT.
- Arbitration is combinational from registered state:
  - Candidates are sources with pending & enable & priority != 0.
  - Highest priority wins; ties go to the lowest ID.
  - best_id / best_prio are 0 when there are no candidates.
- meip is registered: meip <= (best_prio > threshold). Strictly greater.
  - Latency: src sampled high at edge E1 -> pending = 1 after E1 -> meip = 1 after E1+1.
- Claim read at 0x3004:
  - Returns best_id as evaluated in the mem_valid cycle, and moves that source to INFLIGHT at the same edge.
  - best_id = 0: returns 0, no state change.
  - meip updates at the following edge.
- Complete write at 0x3004:
  - ID 0, ID > NSRC, or an ID not INFLIGHT: ignored.
  - A source still asserted re-enters PEND at the edge after completion.
- Simultaneous events:
  - Claim in the same cycle another source rises: that source pends normally.
  - Claimed source's src still high: stays INFLIGHT.
  - Enable or priority write in the same cycle as a claim: claim uses the old values.
- Reset (any cycle, including mid-transaction) clears:
  - all gateways to IDLE, and pending, enable, priority, threshold;
  - meip = 0, mem_ready = 0, mem_rdata = 0.
  - A request in flight at reset gets no response.

Optional Feature:
- PLIC_SYNC_EN defined: src passes through a two-flop synchronizer per bit before the gateways. Source-to-meip latency becomes 4 edges.
- Undefined: src is used directly, and the latency above applies unchanged.

Test Plan:
- Basic path:
  - Stimulus: reset, priority[3] = 2, enable = 0x08, threshold = 0, raise src[2] (ID 3).
  - Required: meip = 1 two edges later; claim returns 3; meip = 0 one edge after the claim; complete(3) with src low keeps meip = 0.
- Arbitration:
  - Stimulus: IDs 2 and 5 both priority 4, ID 7 priority 6, all enabled and asserted.
  - Required: claims return 7, then 2, then 5 (each completed between claims); a fourth claim returns 0.
- Threshold:
  - Stimulus: priority[1] = 3, threshold = 3, src[0] = 1.
  - Required: meip stays 0 and pending reads 0x02. After threshold = 2 is written, meip = 1 within 2 edges.
- Level re-trigger and bogus complete:
  - Stimulus: claim ID 4 with src[3] held high; complete(6); then complete(4).
  - Required: pending bit 4 stays 0 after complete(6); it re-sets one edge after complete(4), and meip returns to 1.
- Reset mid-operation:
  - Stimulus: assert reset in the cycle after a claim mem_valid.
  - Required: mem_ready = 0, meip = 0, all registers read 0 after release.
- Disabled source:
  - Stimulus: enable = 0, src = all ones, priorities = 7.
  - Required: meip = 0, claim returns 0, pending reads all NSRC bits set (0x1FE for NSRC = 8).
